// File: rtl/wb_master_seq.sv
// Queued Wishbone classic master: commands in through a FIFO, one response out per command.
// Each bus or interrupt wait is bounded by a saturating timeout counter.
module wb_master_seq #(
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CMD_DEPTH  = 4,
    parameter int unsigned RSP_DEPTH  = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [1:0]            cmd_op_i,
    input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
    input  logic [DATA_WIDTH-1:0] cmd_dat_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_dat_o,
    output logic                  rsp_err_o,
    output logic                  cyc_o,
    output logic                  stb_o,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] adr_o,
    output logic [DATA_WIDTH-1:0] dat_o,
    input  logic [DATA_WIDTH-1:0] dat_i,
    input  logic                  ack_i,
    input  logic                  irq_i,
    output logic                  busy_o
);
    localparam int unsigned CMD_PW = $clog2(CMD_DEPTH);
    localparam int unsigned RSP_PW = $clog2(RSP_DEPTH);
    localparam int unsigned CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned CMD_W  = 2 + ADDR_WIDTH + DATA_WIDTH;
    localparam int unsigned RSP_W  = DATA_WIDTH + 1;

    localparam logic [CMD_PW:0] CMD_ONE   = 1;
    localparam logic [RSP_PW:0] RSP_ONE   = 1;
    localparam logic [CNT_W:0]  CNT_ONE   = 1;
    localparam logic [CNT_W:0]  CNT_LIMIT = (CNT_W + 1)'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StBus, StIrq, StGap} state_t;

    state_t                r_state, w_state_nxt;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic [CNT_W:0]        w_cnt_inc;
    logic                  w_timeout;
    logic                  r_cyc, w_cyc_nxt;
    logic                  r_we, w_we_nxt;
    logic [ADDR_WIDTH-1:0] r_adr, w_adr_nxt;
    logic [DATA_WIDTH-1:0] r_dat, w_dat_nxt;

    // Command FIFO; pointers carry an extra wrap bit to tell full from empty.
    logic [CMD_W-1:0]      r_cmd_mem [CMD_DEPTH];
    logic [CMD_PW:0]       r_cmd_wp, r_cmd_rp;
    logic                  w_cmd_empty, w_cmd_full, w_cmd_push, w_cmd_pop;
    logic [CMD_W-1:0]      w_cmd_head;
    logic [1:0]            w_head_op;
    logic [ADDR_WIDTH-1:0] w_head_adr;
    logic [DATA_WIDTH-1:0] w_head_dat;

    logic [RSP_W-1:0]      r_rsp_mem [RSP_DEPTH];
    logic [RSP_PW:0]       r_rsp_wp, r_rsp_rp;
    logic                  w_rsp_empty, w_rsp_full, w_rsp_push, w_rsp_pop;
    logic [RSP_W-1:0]      w_rsp_head;
    logic [DATA_WIDTH-1:0] w_rsp_pdat;
    logic                  w_rsp_perr;

    assign w_cmd_empty = (r_cmd_wp == r_cmd_rp);
    assign w_cmd_full  = (r_cmd_wp[CMD_PW] != r_cmd_rp[CMD_PW]) &&
                         (r_cmd_wp[CMD_PW-1:0] == r_cmd_rp[CMD_PW-1:0]);
    assign w_cmd_push  = cmd_valid_i && !w_cmd_full;
    assign w_cmd_head  = r_cmd_mem[r_cmd_rp[CMD_PW-1:0]];
    assign w_head_op   = w_cmd_head[CMD_W-1 -: 2];
    assign w_head_adr  = w_cmd_head[DATA_WIDTH +: ADDR_WIDTH];
    assign w_head_dat  = w_cmd_head[0 +: DATA_WIDTH];

    assign w_rsp_empty = (r_rsp_wp == r_rsp_rp);
    assign w_rsp_full  = (r_rsp_wp[RSP_PW] != r_rsp_rp[RSP_PW]) &&
                         (r_rsp_wp[RSP_PW-1:0] == r_rsp_rp[RSP_PW-1:0]);
    assign w_rsp_pop   = !w_rsp_empty && rsp_ready_i;
    assign w_rsp_head  = r_rsp_mem[r_rsp_rp[RSP_PW-1:0]];

    assign cmd_ready_o = !w_cmd_full;
    assign rsp_valid_o = !w_rsp_empty;
    assign rsp_dat_o   = w_rsp_empty ? '0 : w_rsp_head[RSP_W-1:1];
    assign rsp_err_o   = w_rsp_empty ? 1'b0 : w_rsp_head[0];
    assign cyc_o       = r_cyc;
    assign stb_o       = r_cyc;
    assign we_o        = r_we;
    assign adr_o       = r_adr;
    assign dat_o       = r_dat;
    assign busy_o      = (r_state != StIdle) || !w_cmd_empty;

    assign w_cnt_inc = {1'b0, r_cnt} + CNT_ONE;
    assign w_timeout = (TIMEOUT != 0) && (w_cnt_inc == CNT_LIMIT);

    always_ff @(posedge clk_i) begin
        if (w_cmd_push) r_cmd_mem[r_cmd_wp[CMD_PW-1:0]] <= {cmd_op_i, cmd_adr_i, cmd_dat_i};
        if (w_rsp_push) r_rsp_mem[r_rsp_wp[RSP_PW-1:0]] <= {w_rsp_pdat, w_rsp_perr};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_cyc    <= 1'b0;
            r_we     <= 1'b0;
            r_adr    <= '0;
            r_dat    <= '0;
            r_cmd_wp <= '0;
            r_cmd_rp <= '0;
            r_rsp_wp <= '0;
            r_rsp_rp <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cyc   <= w_cyc_nxt;
            r_we    <= w_we_nxt;
            r_adr   <= w_adr_nxt;
            r_dat   <= w_dat_nxt;
            if (w_cmd_push) r_cmd_wp <= r_cmd_wp + CMD_ONE;
            if (w_cmd_pop)  r_cmd_rp <= r_cmd_rp + CMD_ONE;
            if (w_rsp_push) r_rsp_wp <= r_rsp_wp + RSP_ONE;
            if (w_rsp_pop)  r_rsp_rp <= r_rsp_rp + RSP_ONE;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cyc_nxt   = r_cyc;
        w_we_nxt    = r_we;
        w_adr_nxt   = r_adr;
        w_dat_nxt   = r_dat;
        w_cmd_pop   = 1'b0;
        w_rsp_push  = 1'b0;
        w_rsp_pdat  = '0;
        w_rsp_perr  = 1'b0;
        unique case (r_state)
            StIdle: begin
                // Dispatch only with a response slot guaranteed for the in-flight command.
                if (!w_cmd_empty && !w_rsp_full) begin
                    w_cmd_pop = 1'b1;
                    w_cnt_nxt = '0;
                    if (!w_head_op[1]) begin
                        w_state_nxt = StBus;
                        w_cyc_nxt   = 1'b1;
                        w_we_nxt    = (w_head_op == 2'b00);
                        w_adr_nxt   = w_head_adr;
                        if (w_head_op == 2'b00) w_dat_nxt = w_head_dat;
                    end else begin
                        w_state_nxt = StIrq;
                    end
                end
            end
            StBus: begin
                if (ack_i || w_timeout) begin
                    w_state_nxt = StGap;
                    w_cyc_nxt   = 1'b0;
                    w_we_nxt    = 1'b0;
                    w_rsp_push  = 1'b1;
                    w_rsp_perr  = !ack_i;
                    if (ack_i && !r_we) w_rsp_pdat = dat_i;
                end else if (TIMEOUT != 0) begin
                    w_cnt_nxt = w_cnt_inc[CNT_W-1:0];
                end
            end
            StIrq: begin
                if (irq_i || w_timeout) begin
                    w_state_nxt = StGap;
                    w_rsp_push  = 1'b1;
                    w_rsp_perr  = !irq_i;
                end else if (TIMEOUT != 0) begin
                    w_cnt_nxt = w_cnt_inc[CNT_W-1:0];
                end
            end
            StGap: w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end
endmodule

// File: tb/tb_wb_master_seq.sv
// Directed bench for wb_master_seq with a simple wait-state slave and a vector table.
module tb_wb_master_seq;
    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       cmd_valid_i, cmd_ready_o;
    logic [1:0] cmd_op_i;
    logic [1:0] cmd_adr_i;
    logic [7:0] cmd_dat_i;
    logic       rsp_valid_o, rsp_ready_i;
    logic [7:0] rsp_dat_o;
    logic       rsp_err_o;
    logic       cyc_o, stb_o, we_o;
    logic [1:0] adr_o;
    logic [7:0] dat_o, dat_i;
    logic       ack_i, irq_i, busy_o;

    int checks = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    wb_master_seq #(
        .ADDR_WIDTH(2), .DATA_WIDTH(8), .CMD_DEPTH(4), .RSP_DEPTH(4), .TIMEOUT(8)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
        .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o),
        .rsp_err_o(rsp_err_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
        .dat_i(dat_i), .ack_i(ack_i), .irq_i(irq_i), .busy_o(busy_o)
    );

    // Slave: acks after ws wait states; stray_ack forces ack regardless of cyc.
    logic [7:0] slv_mem [4] = '{8'h10, 8'h11, 8'h12, 8'h13};
    int   ws = 0;
    int   wcnt;
    logic stray_ack = 1'b0;
    assign ack_i = (cyc_o && stb_o && (wcnt == ws)) || stray_ack;
    assign dat_i = slv_mem[adr_o];

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) wcnt <= 0;
        else if (cyc_o && stb_o) wcnt <= ack_i ? 0 : wcnt + 1;
        else wcnt <= 0;
    end

    always @(posedge clk_i) begin
        if (cyc_o && stb_o && we_o && ack_i) slv_mem[adr_o] <= dat_o;
    end

    int cyc_total = 0;
    int we_total = 0;
    always @(negedge clk_i) begin
        if (cyc_o) cyc_total <= cyc_total + 1;
        if (cyc_o && we_o) we_total <= we_total + 1;
    end

    typedef struct {
        logic [1:0] op;
        logic [1:0] adr;
        logic [7:0] dat;
        int         ws;
        logic       irq;
        logic       stray;
        logic [7:0] exp_dat;
        logic       exp_err;
        int         exp_cyc;
        int         exp_we;
    } vec_t;

    vec_t       vecs [12];
    logic [7:0] exp_mem [4];
    logic [7:0] exp_q [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_cmd(input logic [1:0] op, input logic [1:0] adr, input logic [7:0] dat);
        int g = 0;
        cmd_op_i    = op;
        cmd_adr_i   = adr;
        cmd_dat_i   = dat;
        cmd_valid_i = 1'b1;
        while (!cmd_ready_o && g < 200) begin
            @(negedge clk_i);
            g++;
        end
        check("push_accept", {31'd0, cmd_ready_o}, 32'd1);
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_rsp(output logic got, output logic [7:0] d, output logic e);
        int g = 0;
        while (!rsp_valid_o && g < 100) begin
            @(negedge clk_i);
            g++;
        end
        got = rsp_valid_o;
        d   = rsp_dat_o;
        e   = rsp_err_o;
        @(negedge clk_i);
    endtask

    task automatic wait_idle();
        int g = 0;
        while (busy_o && g < 200) begin
            @(negedge clk_i);
            g++;
        end
        check("idle_reached", {31'd0, busy_o}, 32'd0);
        repeat (2) @(negedge clk_i);
    endtask

    // Samples the head before the pop edge so every entry is seen exactly once.
    task automatic collect(input string tag, input int first, input int last);
        int n = first;
        int g = 0;
        while (n < last && g < 400) begin
            if (rsp_valid_o && rsp_ready_i) begin
                check($sformatf("%s_rsp%0d", tag, n), {24'd0, rsp_dat_o}, {24'd0, exp_q[n]});
                n++;
            end
            @(negedge clk_i);
            g++;
        end
        check($sformatf("%s_count", tag), n, last);
    endtask

    initial begin
        logic       got, e;
        logic [7:0] d;
        int         c0, w0;

        vecs[0]  = '{2'b00, 2'd2, 8'h55, 1,   1'b0, 1'b0, 8'h00, 1'b0, 2, 2};
        vecs[1]  = '{2'b01, 2'd2, 8'hEE, 1,   1'b0, 1'b0, 8'h55, 1'b0, 2, 0};
        vecs[2]  = '{2'b00, 2'd1, 8'hA3, 0,   1'b0, 1'b0, 8'h00, 1'b0, 1, 1};
        vecs[3]  = '{2'b01, 2'd1, 8'hEE, 0,   1'b0, 1'b0, 8'hA3, 1'b0, 1, 0};
        vecs[4]  = '{2'b01, 2'd0, 8'hEE, 3,   1'b0, 1'b0, 8'h10, 1'b0, 4, 0};
        vecs[5]  = '{2'b01, 2'd1, 8'hEE, 255, 1'b0, 1'b0, 8'h00, 1'b1, 8, 0};
        vecs[6]  = '{2'b01, 2'd3, 8'hEE, 0,   1'b0, 1'b0, 8'h13, 1'b0, 1, 0};
        vecs[7]  = '{2'b10, 2'd0, 8'hEE, 0,   1'b1, 1'b0, 8'h00, 1'b0, 0, 0};
        vecs[8]  = '{2'b10, 2'd0, 8'hEE, 0,   1'b0, 1'b1, 8'h00, 1'b1, 0, 0};
        vecs[9]  = '{2'b11, 2'd0, 8'hEE, 0,   1'b1, 1'b0, 8'h00, 1'b0, 0, 0};
        vecs[10] = '{2'b00, 2'd3, 8'hFF, 2,   1'b0, 1'b0, 8'h00, 1'b0, 3, 3};
        vecs[11] = '{2'b01, 2'd3, 8'hEE, 0,   1'b0, 1'b0, 8'hFF, 1'b0, 1, 0};
        exp_mem  = '{8'h10, 8'hA3, 8'h55, 8'hFF};

        rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_op_i = '0; cmd_adr_i = '0; cmd_dat_i = '0;
        rsp_ready_i = 1'b1; irq_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_cyc", {31'd0, cyc_o}, 0);
        check("rst_stb", {31'd0, stb_o}, 0);
        check("rst_we", {31'd0, we_o}, 0);
        check("rst_adr", {30'd0, adr_o}, 0);
        check("rst_dat", {24'd0, dat_o}, 0);
        check("rst_cmd_ready", {31'd0, cmd_ready_o}, 1);
        check("rst_rsp_valid", {31'd0, rsp_valid_o}, 0);
        check("rst_rsp_dat", {24'd0, rsp_dat_o}, 0);
        check("rst_rsp_err", {31'd0, rsp_err_o}, 0);
        check("rst_busy", {31'd0, busy_o}, 0);

        for (int i = 0; i < 12; i++) begin
            ws = vecs[i].ws; irq_i = vecs[i].irq; stray_ack = vecs[i].stray;
            c0 = cyc_total; w0 = we_total;
            push_cmd(vecs[i].op, vecs[i].adr, vecs[i].dat);
            wait_rsp(got, d, e);
            check($sformatf("vec%0d_seen", i), {31'd0, got}, 1);
            check($sformatf("vec%0d_dat", i), {24'd0, d}, {24'd0, vecs[i].exp_dat});
            check($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, vecs[i].exp_err});
            wait_idle();
            check($sformatf("vec%0d_cyc_cycles", i), cyc_total - c0, vecs[i].exp_cyc);
            check($sformatf("vec%0d_we_cycles", i), we_total - w0, vecs[i].exp_we);
            irq_i = 1'b0; stray_ack = 1'b0;
        end

        // irq raised mid-wait: response must appear one edge after irq is sampled
        c0 = cyc_total;
        push_cmd(2'b10, 2'd0, 8'h00);
        repeat (4) @(negedge clk_i);
        check("irq_early_valid", {31'd0, rsp_valid_o}, 0);
        irq_i = 1'b1;
        @(negedge clk_i);
        check("irq_rsp_valid", {31'd0, rsp_valid_o}, 1);
        check("irq_rsp_err", {31'd0, rsp_err_o}, 0);
        check("irq_rsp_dat", {24'd0, rsp_dat_o}, 0);
        irq_i = 1'b0;
        wait_idle();
        check("irq_no_bus", cyc_total - c0, 0);

        // Backpressure: 10 reads with responses blocked
        ws = 0; rsp_ready_i = 1'b0; c0 = cyc_total;
        for (int i = 0; i < 10; i++) exp_q[i] = exp_mem[i % 4];
        for (int i = 0; i < 8; i++) push_cmd(2'b01, 2'(i % 4), 8'h00);
        repeat (30) @(negedge clk_i);
        check("bp_bus_cycles", cyc_total - c0, 4);
        check("bp_cmd_ready", {31'd0, cmd_ready_o}, 0);
        check("bp_rsp_valid", {31'd0, rsp_valid_o}, 1);
        check("bp_busy", {31'd0, busy_o}, 1);
        fork
            begin
                push_cmd(2'b01, 2'd0, 8'h00);
                push_cmd(2'b01, 2'd1, 8'h00);
            end
            begin
                rsp_ready_i = 1'b1;
                collect("bp", 0, 10);
            end
        join
        wait_idle();
        check("bp_total_cycles", cyc_total - c0, 10);

        // Push against a full command FIFO in the cycle it is popped
        rsp_ready_i = 1'b0; c0 = cyc_total;
        for (int i = 0; i < 8; i++) begin
            exp_q[i] = exp_mem[3 - (i % 4)];
            push_cmd(2'b01, 2'(3 - (i % 4)), 8'h00);
        end
        exp_q[8] = exp_mem[1];
        repeat (30) @(negedge clk_i);
        check("sim_full", {31'd0, cmd_ready_o}, 0);
        check("sim_rsp0", {24'd0, rsp_dat_o}, {24'd0, exp_q[0]});
        cmd_op_i = 2'b01; cmd_adr_i = 2'd1; cmd_dat_i = 8'h00; cmd_valid_i = 1'b1;
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        check("sim_refused_on_pop", {31'd0, cmd_ready_o}, 0);
        @(negedge clk_i);
        check("sim_ready_after_pop", {31'd0, cmd_ready_o}, 1);
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        collect("sim", 1, 9);
        repeat (20) @(negedge clk_i);
        check("sim_no_extra", {31'd0, rsp_valid_o}, 0);
        check("sim_bus_cycles", cyc_total - c0, 9);

        // Reset asserted while a read is on the bus
        ws = 255;
        push_cmd(2'b01, 2'd0, 8'h00);
        begin
            int g = 0;
            while (!cyc_o && g < 50) begin
                @(negedge clk_i);
                g++;
            end
        end
        check("rst_mid_cyc_before", {31'd0, cyc_o}, 1);
        rst_i = 1'b1;
        #1;
        check("rst_mid_cyc", {31'd0, cyc_o}, 0);
        check("rst_mid_stb", {31'd0, stb_o}, 0);
        check("rst_mid_rsp_valid", {31'd0, rsp_valid_o}, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_mid_cmd_ready", {31'd0, cmd_ready_o}, 1);
        check("rst_mid_busy", {31'd0, busy_o}, 0);
        ws = 0;
        push_cmd(2'b01, 2'd2, 8'h00);
        wait_rsp(got, d, e);
        check("post_rst_seen", {31'd0, got}, 1);
        check("post_rst_dat", {24'd0, d}, 32'h55);
        check("post_rst_err", {31'd0, e}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
